// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one cache put/get port between two requesters.
// Puts are arbitrated round-robin. The requester ID of every accepted put is
// pushed into an in-order tag FIFO. Each get response is steered to the
// requester whose tag sits at the FIFO head.
// Optional build macro CACHE_ARB_STRICT_PRIO_EN: when both requesters are
// valid, requester 0 always wins and requester 1 can starve (debug use only).
module cache_port_arbiter #(
  parameter int REQ_W           = 70,
  parameter int RESP_W          = 52,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_valid,
  input  logic [REQ_W-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REQ_W-1:0]  req1_data,
  output logic              req1_ready,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic              cache_put_valid,
  input  logic              cache_put_ready,
  output logic [REQ_W-1:0]  cache_put_request,
  input  logic              cache_get_ready,
  output logic              cache_get_valid,
  input  logic [RESP_W-1:0] cache_get_response,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_spurious
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Architectural state
  logic             last_grant_q, last_grant_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tag_q [MAX_OUTSTANDING];
  logic             tag_d [MAX_OUTSTANDING];
  logic             err_spurious_q, err_spurious_d;

  // Combinational helpers
  logic grant_s;
  logic full_s;
  logic empty_s;
  logic head_s;
  logic head_ready_s;
  logic put_valid_s;
  logic put_fire_s;
  logic get_valid_s;

  // Pick the winner among the valid requesters; depends only on last_grant,
  // so the choice holds steady while the cache stalls the put channel.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef CACHE_ARB_STRICT_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // FIFO status, head tag and channel handshakes. Every valid/ready output is
  // forced low while reset is asserted, even before the state is known.
  always_comb begin
    full_s       = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty_s      = (count_q == {CNT_W{1'b0}});
    head_s       = tag_q[rd_ptr_q];
    head_ready_s = head_s ? resp1_ready : resp0_ready;
    put_valid_s  = RST_N & (req0_valid | req1_valid) & ~full_s;
    put_fire_s   = put_valid_s & cache_put_ready;
    get_valid_s  = RST_N & cache_get_ready & ~empty_s & head_ready_s;
  end

  // Drive the port-facing outputs from the handshake terms above.
  always_comb begin
    cache_put_valid   = put_valid_s;
    cache_put_request = grant_s ? req1_data : req0_data;
    req0_ready        = put_fire_s & ~grant_s;
    req1_ready        = put_fire_s & grant_s;
    resp0_valid       = RST_N & cache_get_ready & ~empty_s & ~head_s;
    resp1_valid       = RST_N & cache_get_ready & ~empty_s & head_s;
    resp_data         = cache_get_response;
    cache_get_valid   = get_valid_s;
    outstanding       = count_q;
    err_spurious      = err_spurious_q;
  end

  // Next-state computation for the grant history, tag FIFO and error flag.
  always_comb begin
    last_grant_d   = last_grant_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    err_spurious_d = err_spurious_q | (cache_get_ready & empty_s);
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (put_fire_s) begin
      tag_d[wr_ptr_q] = grant_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      last_grant_d    = grant_s;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (get_valid_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A simultaneous put and get leaves the occupancy unchanged.
    case ({put_fire_s, get_valid_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset; in-flight tags are dropped.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_grant_q   <= 1'b1;
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      err_spurious_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else begin
      last_grant_q   <= last_grant_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      err_spurious_q <= err_spurious_d;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one cache port between two requesters, e.g. instruction and data side of a core, or two cores on a shared cache.
- Cache port: put-request channel (70 b) and get-response channel (52 b).
- Block arbitrates puts round-robin and records the requester ID of every accepted put in an in-order tag FIFO.
- Each get response is routed to the requester that issued the corresponding put.
- Sits between the core-side memory interfaces and the cache wrapper.

Parameters:
REQ_W, 70, put request width
RESP_W, 52, get response width
MAX_OUTSTANDING, 4, tag FIFO depth (power of 2, ≥2); max puts accepted without responses
CNT_W, 3, outstanding counter width = clog2(MAX_OUTSTANDING+1)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset, sampled on rising CLK
req0_valid  in  1  requester 0 put valid
req0_data  in  REQ_W  requester 0 put payload
req0_ready  out  1  requester 0 put accepted this cycle
req1_valid  in  1  requester 1 put valid
req1_data  in  REQ_W  requester 1 put payload
req1_ready  out  1  requester 1 put accepted this cycle
resp0_valid  out  1  response for requester 0 available
resp0_ready  in  1  requester 0 consumes response
resp1_valid  out  1  response for requester 1 available
resp1_ready  in  1  requester 1 consumes response
resp_data  out  RESP_W  response payload, shared by both requesters
cache_put_valid  out  1  put request to cache
cache_put_ready  in  1  cache accepts put
cache_put_request  out  REQ_W  muxed put payload
cache_get_ready  in  1  cache has a response at head
cache_get_valid  out  1  dequeue cache response this cycle
cache_get_response  in  RESP_W  cache response payload
outstanding  out  CNT_W  tag FIFO occupancy
err_spurious  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- Transfer rule: a transfer occurs on a channel when valid and ready are both high at the rising edge. Requesters hold valid and data stable until ready.
- State:
  - last_grant (1 b), reset 1, so requester 0 wins first.
  - Tag FIFO: rd_ptr and wr_ptr reset 0, count reset 0, entries 1 b.
  - err_spurious, reset 0.
- While RST_N is low, all valid/ready outputs are 0. outstanding reads 0 from the first cycle after reset.
- Grant (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Grant is stable while the cache stalls, because last_grant updates only on a put transfer.
- full = (count == MAX_OUTSTANDING).
- cache_put_valid = (req0_valid | req1_valid) & !full. It does not depend on cache_put_ready.
- cache_put_request = data of the granted requester.
- reqX_ready = cache_put_valid & grant==X & cache_put_ready.
- On a put transfer:
  - tag[wr_ptr] <= granted ID; wr_ptr increments and wraps modulo depth.
  - last_grant <= granted ID.
- head = tag[rd_ptr]; empty = (count == 0).
- respX_valid = cache_get_ready & !empty & head==X.
- resp_data = cache_get_response.
- cache_get_valid = cache_get_ready & !empty & resp_ready[head]. Zero-latency pass-through.
- On a get transfer, rd_ptr increments and wraps.
- count update:
  - +1 on put only, −1 on get only, unchanged on simultaneous put and get.
  - When full, put is blocked, so a simultaneous get frees the slot for the following cycle only, not the same cycle.
- Spurious response: cache_get_ready & empty sets err_spurious (sticky until reset). The response is not dequeued (cache_get_valid = 0).
- Responses are strictly in put order. A stalled head requester (resp_ready low) blocks the other requester's responses.
- Reset mid-operation clears all state; in-flight tags are discarded. The cache must be reset in the same cycle.
- outstanding = count.

Optional Feature:
- Macro: CACHE_ARB_STRICT_PRIO_EN.
- Defined:
  - Requester 0 always wins when both are valid; last_grant is ignored.
  - Requester 1 can starve. Intended for debug and isolation experiments.
- Undefined: round-robin as above.
- Tag FIFO, routing and all ports are identical in both builds.

Test Plan:
- Reset, then req0_valid=1 with data 0x11, cache_put_ready=1 → req0_ready=1 cycle 0, cache_put_request=0x11, outstanding 0→1.
- Both valid continuously, cache always ready, four cycles → grant order 0,1,0,1. Strict build: 0,0,0,0.
- Cache stalls put 3 cycles with both valid → cache_put_request constant, no reqX_ready. Grant goes to the same requester when ready returns.
- Issue 4 puts (ids 0,1,1,0) without responses → outstanding=4, cache_put_valid=0 despite req valid. Then one get → next cycle a put is accepted again.
- Responses 0xA,0xB,0xC,0xD for tags 0,1,1,0 → resp0_valid, resp1_valid, resp1_valid, resp0_valid in order. resp1_ready=0 holds cache_get_valid=0 and blocks the later entries.
- cache_get_ready=1 with outstanding=0 → cache_get_valid=0, err_spurious=1 next cycle, stays 1 until RST_N=0.
